// File: rtl/ami_mem_responder_pkg.sv
// Shared AMI types and constants for the memory responder: request/response
// payloads and the 64-byte word geometry used to turn byte addresses into RAM rows.
package ami_mem_responder_pkg;

  localparam int AMI_WORD_BYTES = 64;
  localparam int AMI_WORD_LSB   = 6;
  localparam int AMI_DATA_W     = 512;
  localparam int AMI_ADDR_W     = 64;
  localparam int AMI_SIZE_W     = 64;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIRequest;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIResponse;

  // Word offset of a byte address relative to the base of the mapped window.
  function automatic logic [AMI_ADDR_W-1:0] ami_word_offset(
    input logic [AMI_ADDR_W-1:0] addr,
    input logic [AMI_ADDR_W-1:0] base
  );
    return (addr - base) >> AMI_WORD_LSB;
  endfunction

endpackage

// File: rtl/ami_resp_fifo.sv
// Show-ahead response FIFO: the head entry is presented whenever the FIFO is
// non-empty, and an all-zero response is presented while it is empty.
module ami_resp_fifo
  import ami_mem_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  AMIResponse               i_push_data,
  input  logic                     i_pop,
  output AMIResponse               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  AMIResponse       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ami_mem_responder.sv
// AMI memory-port responder backed by an on-chip 512-bit RAM with in-order read
// responses. Define AMI_MEM_BOUNDS_EN to enable the out-of-range check and err_oob.
module ami_mem_responder
  import ami_mem_responder_pkg::*;
#(
  parameter int              MEM_WORDS  = 1024,
  parameter int              RD_LATENCY = 2,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [63:0]     BASE_ADDR  = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  AMIRequest   mem_req,
  output logic        mem_req_grant,
  output AMIResponse  mem_resp,
  input  logic        mem_resp_grant,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        err_oob
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a request transfers on a clock edge where mem_req.valid and
  // mem_req_grant are both high; a response transfers where mem_resp.valid and
  // mem_resp_grant are both high. Grant depends on registered state only.

  logic [AMI_DATA_W-1:0] r_mem [MEM_WORDS];
  logic [CNT_W-1:0]      r_credits;
  logic [31:0]           r_rd_count;
  logic [31:0]           r_wr_count;
  logic                  r_s0_vld;
  logic [IDX_W-1:0]      r_s0_idx;
  logic                  r_s0_oob;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [AMI_DATA_W-1:0] r_pipe_data [RD_LATENCY];

  logic                  w_acc;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_pop;
  logic                  w_oob;
  logic [63:0]           w_word;
  logic [IDX_W-1:0]      w_idx;
  AMIResponse            w_push_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_unused;

  assign mem_req_grant = !rst && (r_credits != CNT_W'(FIFO_DEPTH));
  assign w_acc         = mem_req.valid && mem_req_grant;
  assign w_rd_acc      = w_acc && !mem_req.isWrite;
  assign w_wr_acc      = w_acc && mem_req.isWrite;
  assign w_word        = ami_word_offset(mem_req.addr, BASE_ADDR);
  assign w_idx         = w_word[IDX_W-1:0];
  assign w_pop         = mem_resp.valid && mem_resp_grant;

`ifdef AMI_MEM_BOUNDS_EN
  logic r_err_oob;

  assign w_oob   = (mem_req.addr < BASE_ADDR) || (w_word >= 64'(MEM_WORDS));
  assign err_oob = r_err_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_oob <= 1'b0;
    end else if (w_acc && w_oob) begin
      r_err_oob <= 1'b1;
    end
  end
`else
  assign w_oob   = 1'b0;
  assign err_oob = 1'b0;
`endif

  // Writes commit on the accept edge, so a read accepted one cycle later
  // already sees the new word when it samples the RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_oob) begin
      r_mem[w_idx] <= mem_req.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_vld <= 1'b0;
      r_s0_idx <= '0;
      r_s0_oob <= 1'b0;
    end else begin
      r_s0_vld <= w_rd_acc;
      r_s0_idx <= w_idx;
      r_s0_oob <= w_oob;
    end
  end

  always_ff @(posedge clk) begin
    r_pipe_data[0] <= r_s0_oob ? '0 : r_mem[r_s0_idx];
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_pipe_data[i] <= r_pipe_data[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= r_s0_vld;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
    end
  end

  assign w_push_data.valid = 1'b1;
  assign w_push_data.data  = r_pipe_data[RD_LATENCY-1];
  assign w_push_data.size  = 64'(AMI_WORD_BYTES);

  ami_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_pipe_vld[RD_LATENCY-1]),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (mem_resp),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // One credit per read from accept until its response is popped; this bound
  // is what keeps the FIFO from ever overflowing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= '0;
    end else begin
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits + CNT_W'(1);
        2'b01:   r_credits <= r_credits - CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_acc) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr_acc) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  assign w_unused = ^{mem_req.size, w_word, w_fifo_full, w_fifo_empty, w_fifo_count};

endmodule

// File: tb/tb_ami_mem_responder.sv
// Bench for ami_mem_responder: directed scenarios plus randomized traffic,
// with responses scored against a word-array memory model and expected queue.
module tb_ami_mem_responder;
  import ami_mem_responder_pkg::*;

  localparam int          MEM_WORDS  = 1024;
  localparam int          RD_LATENCY = 2;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [63:0] BASE       = 64'h0;

  logic        clk;
  logic        rst;
  AMIRequest   mem_req;
  logic        mem_req_grant;
  AMIResponse  mem_resp;
  logic        mem_resp_grant;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        err_oob;

  int checks;
  int errors;
  int resp_seen;
  int m_rd;
  int m_wr;
  bit m_err;
  logic [511:0] model_mem [MEM_WORDS];
  logic [511:0] exp_q[$];

  ami_mem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .RD_LATENCY (RD_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_req_grant  (mem_req_grant),
    .mem_resp       (mem_resp),
    .mem_resp_grant (mem_resp_grant),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .err_oob        (err_oob)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model helpers ----------------
  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'(((a - BASE) >> 6) % 64'(MEM_WORDS));
  endfunction

  function automatic bit is_oob(input logic [63:0] a);
`ifdef AMI_MEM_BOUNDS_EN
    return (a < BASE) || (((a - BASE) >> 6) >= 64'(MEM_WORDS));
`else
    return (a != a);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    mem_req = '0;
  endtask

  task automatic set_read(input logic [63:0] a);
    mem_req         = '0;
    mem_req.valid   = 1'b1;
    mem_req.isWrite = 1'b0;
    mem_req.addr    = a;
    mem_req.size    = 64'(64);
  endtask

  task automatic set_write(input logic [63:0] a, input logic [511:0] d);
    mem_req         = '0;
    mem_req.valid   = 1'b1;
    mem_req.isWrite = 1'b1;
    mem_req.addr    = a;
    mem_req.data    = d;
    mem_req.size    = 64'($urandom_range(0, 255));
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while ((exp_q.size() != 0 || mem_resp.valid) && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!mem_resp.valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic clear_model_on_reset();
    exp_q.delete();
    m_rd  = 0;
    m_wr  = 0;
    m_err = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    mem_resp_grant = 1'b1;
    clear_model_on_reset();
    step(); step();
    checks++; if (mem_req_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", mem_req_grant); end
    checks++; if (mem_resp.valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", mem_resp.valid); end
    checks++; if (mem_resp.data !== 512'd0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", mem_resp.data); end
    checks++; if (mem_resp.size !== 64'd0) begin errors++; $display("FAIL reset_resp_size: got %0d want 0", mem_resp.size); end
    checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin errors++; $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err_oob: got %b want 0", err_oob); end
    rst = 1'b0;
    #1;
    checks++; if (mem_req_grant !== 1'b1) begin errors++; $display("FAIL reset_release_grant: got %b want 1", mem_req_grant); end
    step();
  endtask

  task automatic test_basic();
    logic [511:0] pat;
    int n;
    for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'hA5;
    set_write(64'h40, pat);
    step();
    set_read(64'h40);
    step();
    set_idle();
    wait_valid(n);
    checks++; if (n >= 40) begin errors++; $display("FAIL basic_timeout: no response after %0d cycles", n); end
    checks++; if (mem_resp.data !== pat) begin errors++; $display("FAIL basic_data: got %h want %h", mem_resp.data, pat); end
    checks++; if (mem_resp.size !== 64'd64) begin errors++; $display("FAIL basic_size: got %0d want 64", mem_resp.size); end
    step();
    checks++; if (rd_count !== 32'd1 || wr_count !== 32'd1) begin errors++; $display("FAIL basic_counts: got rd=%0d wr=%0d want 1/1", rd_count, wr_count); end
  endtask

  task automatic test_raw();
    logic [511:0] d;
    int n;
    d = rand512();
    set_write(64'h80, d);
    step();
    set_read(64'h80);
    step();
    set_idle();
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_resp.valid && n < 20);
    checks++; if (n != RD_LATENCY + 1) begin errors++; $display("FAIL raw_latency: got %0d cycles want %0d", n, RD_LATENCY + 1); end
    checks++; if (mem_resp.data !== d) begin errors++; $display("FAIL raw_data: got %h want %h", mem_resp.data, d); end
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      set_write(64'(i) * 64, rand512());
      step();
    end
    set_idle();
    step();
  endtask

  task automatic test_backpressure();
    int acc;
    int base;
    int cyc;
    logic [511:0] held;
    acc = 0;
    mem_resp_grant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_read(64'($urandom_range(0, 15)) * 64);
      if (mem_req_grant) acc++;
      step();
    end
    set_idle();
    step(); step(); step();
    checks++; if (acc != FIFO_DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", acc, FIFO_DEPTH); end
    checks++; if (mem_req_grant !== 1'b0) begin errors++; $display("FAIL bp_grant_low: got %b want 0", mem_req_grant); end
    held = mem_resp.data;
    step(); step();
    checks++; if (mem_resp.valid !== 1'b1 || mem_resp.data !== held) begin errors++; $display("FAIL bp_stable: got valid=%b data=%h want valid=1 data=%h", mem_resp.valid, mem_resp.data, held); end
    base = resp_seen;
    mem_resp_grant = 1'b1;
    drain(cyc);
    checks++; if (resp_seen - base != FIFO_DEPTH) begin errors++; $display("FAIL bp_resp_count: got %0d want %0d", resp_seen - base, FIFO_DEPTH); end
    checks++; if (mem_req_grant !== 1'b1) begin errors++; $display("FAIL bp_grant_back: got %b want 1", mem_req_grant); end
  endtask

  task automatic test_back_to_back();
    int grant_low;
    int vcount;
    int first;
    int last;
    grant_low = 0;
    vcount = 0;
    first = -1;
    last = -1;
    mem_resp_grant = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c < 30) begin
        set_read(64'($urandom_range(0, 15)) * 64);
        if (!mem_req_grant) grant_low++;
      end else begin
        set_idle();
      end
      if (mem_resp.valid) begin
        vcount++;
        if (first < 0) first = c;
        last = c;
      end
      step();
    end
    checks++; if (grant_low != 0) begin errors++; $display("FAIL b2b_grant: got %0d stalled cycles want 0", grant_low); end
    checks++; if (vcount != 30 || last - first + 1 != 30) begin errors++; $display("FAIL b2b_rate: got %0d responses over %0d cycles want 30 over 30", vcount, last - first + 1); end
  endtask

  task automatic test_random();
    logic [63:0] a;
    int cyc;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 7) begin
        a = 64'($urandom_range(0, 15)) * 64 + 64'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) set_write(a, rand512());
        else set_read(a);
      end else begin
        set_idle();
      end
      mem_resp_grant = 1'($urandom_range(0, 1));
      step();
    end
    set_idle();
    mem_resp_grant = 1'b1;
    drain(cyc);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d outstanding want 0", exp_q.size()); end
    checks++; if (rd_count !== 32'(m_rd)) begin errors++; $display("FAIL rand_rd_count: got %0d want %0d", rd_count, m_rd); end
    checks++; if (wr_count !== 32'(m_wr)) begin errors++; $display("FAIL rand_wr_count: got %0d want %0d", wr_count, m_wr); end
  endtask

  task automatic test_reset_inflight();
    logic [511:0] d;
    int n;
    d = model_mem[5];
    mem_resp_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_read(64'($urandom_range(0, 15)) * 64);
      step();
    end
    set_idle();
    rst = 1'b1;
    clear_model_on_reset();
    #1;
    checks++; if (mem_resp.valid !== 1'b0) begin errors++; $display("FAIL rst_inflight_valid: got %b want 0", mem_resp.valid); end
    checks++; if (mem_req_grant !== 1'b0) begin errors++; $display("FAIL rst_inflight_grant: got %b want 0", mem_req_grant); end
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (mem_req_grant !== 1'b1) begin errors++; $display("FAIL rst_release_grant: got %b want 1", mem_req_grant); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem_resp.valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale_resp: got valid=1 at cycle %0d want 0", i); end
      step();
    end
    checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin errors++; $display("FAIL rst_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count); end
    set_read(64'd5 * 64);
    step();
    set_idle();
    wait_valid(n);
    checks++; if (mem_resp.data !== d) begin errors++; $display("FAIL rst_ram_kept: got %h want %h", mem_resp.data, d); end
    step();
  endtask

  task automatic test_bounds();
    logic [511:0] d;
    logic [511:0] w0;
    int n;
    d = rand512();
    w0 = model_mem[0];
    mem_resp_grant = 1'b1;
`ifdef AMI_MEM_BOUNDS_EN
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_initial: got %b want 0", err_oob); end
    set_read(64'(MEM_WORDS) * 64);
    step();
    set_idle();
    wait_valid(n);
    checks++; if (mem_resp.data !== 512'd0) begin errors++; $display("FAIL oob_read_data: got %h want 0", mem_resp.data); end
    step();
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_flag: got %b want 1", err_oob); end
    set_write(64'(MEM_WORDS) * 64, d);
    step();
    set_read(64'h0);
    step();
    set_idle();
    wait_valid(n);
    checks++; if (mem_resp.data !== w0) begin errors++; $display("FAIL oob_write_dropped: got %h want %h", mem_resp.data, w0); end
    step(); step(); step();
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", err_oob); end
`else
    set_write(64'(MEM_WORDS) * 64, d);
    step();
    set_read(64'h0);
    step();
    set_idle();
    wait_valid(n);
    checks++; if (mem_resp.data !== d || d === w0) begin errors++; $display("FAIL wrap_data: got %h want %h", mem_resp.data, d); end
    step();
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL wrap_err_oob: got %b want 0", err_oob); end
`endif
    checks++; if (wr_count !== 32'(m_wr) || rd_count !== 32'(m_rd)) begin errors++; $display("FAIL bound_counts: got rd=%0d wr=%0d want %0d/%0d", rd_count, wr_count, m_rd, m_wr); end
  endtask

  // ---------------- main sequence with scoreboard ----------------
  initial begin
    logic [511:0] exp_d;
    int cyc;
    checks    = 0;
    errors    = 0;
    resp_seen = 0;
    rst       = 1'b1;
    mem_req   = '0;
    mem_resp_grant = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
          if (mem_resp.valid && mem_resp_grant) begin
            resp_seen++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_extra_resp: got data=%h with none expected", mem_resp.data);
            end else begin
              exp_d = exp_q.pop_front();
              if (mem_resp.data !== exp_d || mem_resp.size !== 64'd64) begin
                errors++;
                $display("FAIL sb_resp: got size=%0d data=%h want size=64 data=%h", mem_resp.size, mem_resp.data, exp_d);
              end
            end
          end
          if (mem_req.valid && mem_req_grant) begin
            if (mem_req.isWrite) begin
              m_wr++;
              if (!is_oob(mem_req.addr)) model_mem[word_of(mem_req.addr)] = mem_req.data;
            end else begin
              m_rd++;
              exp_q.push_back(is_oob(mem_req.addr) ? 512'd0 : model_mem[word_of(mem_req.addr)]);
            end
            if (is_oob(mem_req.addr)) m_err = 1'b1;
          end
        end
      end
    join_none

    test_reset();
    test_basic();
    test_raw();
    test_fill();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    test_bounds();

    set_idle();
    mem_resp_grant = 1'b1;
    drain(cyc);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: got %0d outstanding want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
